// File: rtl/liang.sv
// liang: shared types for the writeback/memory stage (element, decoded uop, mem size, FSM state)
package liang;
  typedef logic [31:0] ele_t;
  typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_load;
    logic        is_store;
    mem_size_e   mem_size;
    logic        mem_signed;
    ele_t        st_data;
  } uop_info_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_COMMIT} state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load byte/half extraction with sign/zero extension, store strobe and lane replication
// Ports: addr_i (low address bits), size_i, signed_i, st_data_i, rdata_i -> ld_data_o, wstrb_o, wdata_o
module lsu_align
  import liang::*;
(
  input  logic [1:0] addr_i,
  input  mem_size_e  size_i,
  input  logic       signed_i,
  input  ele_t       st_data_i,
  input  ele_t       rdata_i,
  output ele_t       ld_data_o,
  output logic [3:0] wstrb_o,
  output ele_t       wdata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = size_i == MEM_B ? {{24{signed_i & b[7]}}, b}
              : size_i == MEM_H ? {{16{signed_i & h[15]}}, h} : rdata_i;
    wstrb_o = size_i == MEM_B ? 4'b0001 << addr_i
            : size_i == MEM_H ? 4'b0011 << {addr_i[1], 1'b0} : 4'b1111;
    wdata_o = size_i == MEM_B ? {4{st_data_i[7:0]}}
            : size_i == MEM_H ? {2{st_data_i[15:0]}} : st_data_i;
  end
endmodule

// File: rtl/pipe_wbu.sv
// pipe_wbu: writeback stage; ALU uops commit next cycle, loads/stores run a req/resp memory handshake
// Ports: clk_i, rst_i (async, active high); uop_info_i/exu_output_i/ex_valid_i in, wb_ready_o out;
//   mem_req_* out with mem_req_ready_i, mem_resp_valid_i/mem_resp_rdata_i in; rf_wen_o/rf_waddr_o/rf_wdata_o out.
// Optional PIPE_WBU_COMMIT_TRACE_EN adds commit_valid_o/commit_pc_o, pulsed on every COMMIT cycle.
module pipe_wbu
  import liang::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  uop_info_t   uop_info_i,
  input  ele_t        exu_output_i,
  input  logic        ex_valid_i,
  output logic        wb_ready_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  output logic        mem_req_wen_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_wstrb_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_rdata_i,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output ele_t        rf_wdata_o
`ifdef PIPE_WBU_COMMIT_TRACE_EN
  ,
  output logic        commit_valid_o,
  output logic [31:0] commit_pc_o
`endif
);
  state_e    state_q, state_d;
  uop_info_t uop_q, uop_d;
  ele_t      exu_q, exu_d, ld_q, ld_d, ld_data, wdata;
  logic [3:0] wstrb;
  logic accept, in_req, in_commit;

  lsu_align u_align (
    .addr_i    (exu_q[1:0]),
    .size_i    (uop_q.mem_size),
    .signed_i  (uop_q.mem_signed),
    .st_data_i (uop_q.st_data),
    .rdata_i   (mem_resp_rdata_i),
    .ld_data_o (ld_data),
    .wstrb_o   (wstrb),
    .wdata_o   (wdata)
  );

  always_comb begin
    wb_ready_o = state_q == S_IDLE || state_q == S_COMMIT;
    accept = ex_valid_i && wb_ready_o;
    uop_d = accept ? uop_info_i : uop_q;
    exu_d = accept ? exu_output_i : exu_q;
    ld_d = state_q == S_RESP && mem_resp_valid_i && uop_q.is_load ? ld_data : ld_q;
    state_d = accept ? (uop_info_i.is_load || uop_info_i.is_store ? S_REQ : S_COMMIT)
            : state_q == S_REQ  ? (mem_req_ready_i ? S_RESP : S_REQ)
            : state_q == S_RESP ? (mem_resp_valid_i ? S_COMMIT : S_RESP) : S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      uop_q   <= '0;
      exu_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      exu_q   <= exu_d;
      ld_q    <= ld_d;
    end
  end

  // Outputs are gated by state so every field reads zero outside the cycles that own it.
  assign in_req          = state_q == S_REQ;
  assign in_commit       = state_q == S_COMMIT;
  assign mem_req_valid_o = in_req;
  assign mem_req_addr_o  = in_req ? {exu_q[31:2], 2'b00} : '0;
  assign mem_req_wen_o   = in_req && uop_q.is_store;
  assign mem_req_wdata_o = in_req && uop_q.is_store ? wdata : '0;
  assign mem_req_wstrb_o = in_req && uop_q.is_store ? wstrb : '0;
  assign rf_wen_o        = in_commit && uop_q.rd_wen && !uop_q.is_store && uop_q.rd != '0;
  assign rf_waddr_o      = in_commit ? uop_q.rd : '0;
  assign rf_wdata_o      = !in_commit ? '0 : uop_q.is_load ? ld_q : exu_q;

`ifdef PIPE_WBU_COMMIT_TRACE_EN
  assign commit_valid_o = in_commit;
  assign commit_pc_o    = in_commit ? uop_q.pc : '0;
`else
  logic unused_pc;
  assign unused_pc = ^uop_q.pc;
`endif
endmodule

// File: tb/tb_pipe_wbu.sv
// tb_pipe_wbu: directed self-checking bench for pipe_wbu
module tb_pipe_wbu;
  import liang::*;
  logic clk_i = 0, rst_i = 1;
  uop_info_t uop = '0;
  ele_t exu = '0;
  logic ex_valid = 0, ready = 0, resp_valid = 0;
  logic [31:0] rdata = '0;
  logic wb_ready, mem_valid, mem_wen, rf_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [4:0] rf_waddr;
  ele_t rf_wdata;
`ifdef PIPE_WBU_COMMIT_TRACE_EN
  logic commit_valid;
  logic [31:0] commit_pc;
`endif
  int checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_wbu dut (
    .clk_i(clk_i), .rst_i(rst_i), .uop_info_i(uop), .exu_output_i(exu), .ex_valid_i(ex_valid),
    .wb_ready_o(wb_ready), .mem_req_valid_o(mem_valid), .mem_req_ready_i(ready),
    .mem_req_addr_o(mem_addr), .mem_req_wen_o(mem_wen), .mem_req_wdata_o(mem_wdata),
    .mem_req_wstrb_o(mem_wstrb), .mem_resp_valid_i(resp_valid), .mem_resp_rdata_i(rdata),
    .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
`ifdef PIPE_WBU_COMMIT_TRACE_EN
    , .commit_valid_o(commit_valid), .commit_pc_o(commit_pc)
`endif
  );

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  function automatic uop_info_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                                   input logic ld, input logic st, input mem_size_e sz,
                                   input logic sg, input ele_t sd);
    uop_info_t u;
    u.pc = pc; u.rd = rd; u.rd_wen = wen; u.is_load = ld; u.is_store = st;
    u.mem_size = sz; u.mem_signed = sg; u.st_data = sd;
    return u;
  endfunction

  task automatic test_reset;
    rst_i = 1;
    cyc; cyc;
    checks++;
    if ({wb_ready, mem_valid, mem_wen, rf_wen} !== 4'b1000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=1000", {wb_ready, mem_valid, mem_wen, rf_wen});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, rf_waddr, rf_wdata} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wstrb, rf_waddr, rf_wdata);
    end
    rst_i = 0;
    cyc;
    checks++;
    if ({wb_ready, mem_valid, rf_wen} !== 3'b100) begin
      failures++; $display("FAIL post_reset got=%b exp=100", {wb_ready, mem_valid, rf_wen});
    end
  endtask

  task automatic test_alu;
    cyc;
    uop = mk(32'h40, 5'd5, 1, 0, 0, MEM_W, 0, 0); exu = 32'h1234; ex_valid = 1;
    #1;
    checks++;
    if (wb_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", wb_ready); end
    cyc;
    ex_valid = 0;
    #1;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      failures++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/00001234", rf_wen, rf_waddr, rf_wdata);
    end
    cyc;
    checks++;
    if (rf_wen !== 1'b0) begin failures++; $display("FAIL alu_one_shot got=%b exp=0", rf_wen); end
  endtask

  task automatic test_back_to_back;
    cyc;
    uop = mk(32'h50, 5'd1, 1, 0, 0, MEM_W, 0, 0); exu = 32'h11; ex_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc;
      if (i < 3) begin
        uop.rd = 5'(i + 1); exu = 32'(32'h11 * (i + 1));
      end else ex_valid = 0;
      #1;
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata, wb_ready} !== {1'b1, 5'(i), 32'(32'h11 * i), 1'b1}) begin
        failures++; $display("FAIL b2b_%0d got=%b/%0d/%h/%b exp=1/%0d/%h/1", i, rf_wen, rf_waddr, rf_wdata, wb_ready, i, 32'h11 * i);
      end
    end
    cyc;
    checks++;
    if (rf_wen !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", rf_wen); end
  endtask

  task automatic test_load;
    logic [31:0] addr [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h107, 32'h101};
    mem_size_e   sz   [6] = '{MEM_B, MEM_B, MEM_H, MEM_H, MEM_W, MEM_B};
    logic        sg   [6] = '{1, 0, 1, 0, 1, 1};
    logic [31:0] rd   [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h1234_8001, 32'hDEAD_BEEF, 32'h0000_7F00};
    logic [31:0] ex   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      cyc;
      uop = mk(32'h100 + 32'(i), 5'd7, 1, 1, 0, sz[i], sg[i], 32'hFFFF_FFFF); exu = addr[i]; ex_valid = 1;
      cyc;
      ex_valid = 0; ready = 1;
      #1;
      checks++;
      if ({mem_valid, mem_addr, mem_wen, mem_wstrb, wb_ready} !== {1'b1, addr[i] & ~32'h3, 1'b0, 4'b0000, 1'b0}) begin
        failures++; $display("FAIL load_req_%0d got=%b/%h/%b/%b/%b exp=1/%h/0/0000/0", i, mem_valid, mem_addr, mem_wen, mem_wstrb, wb_ready, addr[i] & ~32'h3);
      end
      cyc;
      ready = 0; resp_valid = 1; rdata = rd[i];
      #1;
      checks++;
      if ({mem_valid, wb_ready, rf_wen} !== 3'b000) begin
        failures++; $display("FAIL load_resp_%0d got=%b exp=000", i, {mem_valid, wb_ready, rf_wen});
      end
      cyc;
      resp_valid = 0; rdata = '0;
      #1;
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, ex[i]}) begin
        failures++; $display("FAIL load_data_%0d got=%b/%0d/%h exp=1/7/%h", i, rf_wen, rf_waddr, rf_wdata, ex[i]);
      end
    end
  endtask

  task automatic test_store_stall;
    cyc;
    uop = mk(32'h200, 5'd9, 1, 0, 1, MEM_H, 0, 32'h0000_ABCD); exu = 32'h202; ex_valid = 1;
    cyc;
    ex_valid = 0; ready = 0; resp_valid = 1; rdata = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, wb_ready} !== {1'b1, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0}) begin
        failures++; $display("FAIL sh_stall_%0d got=%b/%h/%b/%b/%h/%b exp=1/00000200/1/1100/abcdabcd/0", k, mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, wb_ready);
      end
      cyc;
    end
    resp_valid = 0; ready = 1;
    #1;
    checks++;
    if (mem_valid !== 1'b1) begin failures++; $display("FAIL sh_still_req got=%b exp=1", mem_valid); end
    cyc;
    ready = 0; resp_valid = 1;
    cyc;
    resp_valid = 0;
    #1;
    checks++;
    if ({rf_wen, wb_ready, mem_valid} !== 3'b010) begin
      failures++; $display("FAIL sh_commit got=%b exp=010", {rf_wen, wb_ready, mem_valid});
    end
  endtask

  task automatic test_store_lanes;
    logic [31:0] addr [2] = '{32'h1, 32'h3};
    mem_size_e   sz   [2] = '{MEM_B, MEM_W};
    logic [31:0] sd   [2] = '{32'h1234_565A, 32'hCAFE_F00D};
    logic [3:0]  es   [2] = '{4'b0010, 4'b1111};
    logic [31:0] ed   [2] = '{32'h5A5A_5A5A, 32'hCAFE_F00D};
    for (int i = 0; i < 2; i++) begin
      cyc;
      uop = mk(32'h300, 5'd3, 1, 0, 1, sz[i], 0, sd[i]); exu = addr[i]; ex_valid = 1;
      cyc;
      ex_valid = 0; ready = 1;
      #1;
      checks++;
      if ({mem_addr, mem_wen, mem_wstrb, mem_wdata} !== {32'h0, 1'b1, es[i], ed[i]}) begin
        failures++; $display("FAIL st_lane_%0d got=%h/%b/%b/%h exp=00000000/1/%b/%h", i, mem_addr, mem_wen, mem_wstrb, mem_wdata, es[i], ed[i]);
      end
      cyc;
      ready = 0; resp_valid = 1;
      cyc;
      resp_valid = 0;
      #1;
      checks++;
      if (rf_wen !== 1'b0) begin failures++; $display("FAIL st_no_wb_%0d got=%b exp=0", i, rf_wen); end
    end
  endtask

  task automatic test_reset_mid;
    cyc;
    uop = mk(32'h400, 5'd4, 1, 1, 0, MEM_W, 0, 0); exu = 32'h300; ex_valid = 1;
    cyc;
    ex_valid = 0; ready = 1;
    cyc;
    ready = 0;
    #1;
    checks++;
    if ({wb_ready, mem_valid} !== 2'b00) begin failures++; $display("FAIL mid_in_resp got=%b exp=00", {wb_ready, mem_valid}); end
    rst_i = 1;
    #1;
    checks++;
    if ({wb_ready, mem_valid, rf_wen, mem_addr} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL mid_async got=%b/%h exp=100/00000000", {wb_ready, mem_valid, rf_wen}, mem_addr);
    end
    cyc;
    rst_i = 0; resp_valid = 1; rdata = 32'h55;
    cyc;
    resp_valid = 0;
    #1;
    checks++;
    if ({rf_wen, wb_ready, mem_valid} !== 3'b010) begin
      failures++; $display("FAIL mid_late_resp got=%b exp=010", {rf_wen, wb_ready, mem_valid});
    end
    cyc;
    checks++;
    if ({rf_wen, wb_ready} !== 2'b01) begin failures++; $display("FAIL mid_after got=%b exp=01", {rf_wen, wb_ready}); end
  endtask

  task automatic test_rd0;
    cyc;
    uop = mk(32'h88, 5'd0, 1, 0, 0, MEM_W, 0, 0); exu = 32'h77; ex_valid = 1;
    cyc;
    ex_valid = 0;
    #1;
    checks++;
    if ({rf_wen, wb_ready} !== 2'b01) begin failures++; $display("FAIL rd0_no_write got=%b exp=01", {rf_wen, wb_ready}); end
`ifdef PIPE_WBU_COMMIT_TRACE_EN
    checks++;
    if ({commit_valid, commit_pc} !== {1'b1, 32'h88}) begin
      failures++; $display("FAIL rd0_trace got=%b/%h exp=1/00000088", commit_valid, commit_pc);
    end
`endif
    cyc;
`ifdef PIPE_WBU_COMMIT_TRACE_EN
    checks++;
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL trace_pulse got=%b exp=0", commit_valid); end
`endif
    checks++;
    if (rf_wen !== 1'b0) begin failures++; $display("FAIL rd0_idle got=%b exp=0", rf_wen); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_load;
    test_store_stall;
    test_store_lanes;
    test_reset_mid;
    test_rd0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_wbu.md
PIPE_WBU -- requirements
Module: pipe_wbu

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk_i  input  1  sole clock; all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 uop_info_i  input  uop_info_t  decoded uop from execute stage.
REQ-005 exu_output_i  input  ele_t  ALU result, or effective address for load/store.
REQ-006 ex_valid_i  input  1  execute stage holds a valid uop.
REQ-007 wb_ready_o  output  1  this stage accepts a uop this cycle.
REQ-008 mem_req_valid_o  output  1  memory request valid.
REQ-009 mem_req_ready_i  input  1  memory accepts request.
REQ-010 mem_req_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-011 mem_req_wen_o  output  1  1 = store, 0 = load.
REQ-012 mem_req_wdata_o  output  32  store data replicated into lanes.
REQ-013 mem_req_wstrb_o  output  4  byte strobes; 0000 for loads.
REQ-014 mem_resp_valid_i  input  1  response valid: load data or store ack.
REQ-015 mem_resp_rdata_i  input  32  load word.
REQ-016 rf_wen_o  output  1  register-file write enable.
REQ-017 rf_waddr_o  output  5  destination register.
REQ-018 rf_wdata_o  output  ele_t  writeback data.

Function
REQ-019 FSM states SHALL be IDLE, REQ, RESP, COMMIT.
REQ-020 wb_ready_o SHALL be 1 in IDLE and COMMIT, else 0; accept = ex_valid_i && wb_ready_o.
REQ-021 On accept, uop_info_i and exu_output_i SHALL be registered; next state REQ if is_load or is_store, else COMMIT.
REQ-022 Without accept, IDLE SHALL stay IDLE and COMMIT SHALL return to IDLE.
REQ-023 REQ: mem_req_valid_o = 1 with address, wen, wdata and wstrb held stable until mem_req_ready_i; then RESP.
REQ-024 RESP: wait for mem_resp_valid_i; loads latch the extended data; then COMMIT. mem_resp_valid_i outside RESP SHALL be ignored.
REQ-025 COMMIT, lasting one cycle: rf_wen_o = rd_wen && (rd != 0); rf_waddr_o = rd; rf_wdata_o = load data for loads, else the registered exu_output.
REQ-026 Latency: an ALU uop writes the register file 1 cycle after accept, with back-to-back throughput of 1/cycle. A memory uop writes 1 cycle after the response.
REQ-027 Load extract: mem_size 0 selects byte addr[1:0]; 1 selects half addr[1]; 2 selects the word. Sign-extend when mem_signed, else zero-extend.
REQ-028 Store strobes: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],1'b0}; word = 1111. Misaligned low address bits beyond the size SHALL be ignored.
REQ-029 Stores SHALL never assert rf_wen_o.

Reset
REQ-030 On rst_i the FSM SHALL go to IDLE, and all outputs SHALL be 0 except wb_ready_o, which SHALL be 1.
REQ-031 Reset during REQ or RESP SHALL abandon the transaction with no register-file write; a late response SHALL be ignored.

Configuration
REQ-032 Macro PIPE_WBU_COMMIT_TRACE_EN, when defined, SHALL add outputs commit_valid_o (1) and commit_pc_o (32), pulsed in every COMMIT cycle including stores and rd = 0.
REQ-033 Without PIPE_WBU_COMMIT_TRACE_EN, those ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-034 Package liang SHALL hold ele_t (32 bits) and uop_info_t (pc, rd[4:0], rd_wen, is_load, is_store, mem_size[1:0], mem_signed, st_data), plus a mem-size enum.
REQ-035 Combinational sub-module lsu_align SHALL perform load extraction/extension and store strobe/data generation.

Verification
REQ-036 ALU uop rd=5, result 0x1234 -> rf write x5=0x1234 the cycle after accept; back-to-back uops on consecutive cycles -> consecutive writes.
REQ-037 lb, addr 0x103, rdata 0x80FF_0000 -> rf_wdata 0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-038 sh, addr 0x202, st_data 0xABCD -> addr 0x200, wstrb 1100, wdata 0xABCD_ABCD, no rf write.
REQ-039 mem_req_ready_i held low 3 cycles -> request fields stable and wb_ready_o = 0 throughout.
REQ-040 rst_i asserted in RESP, then a response arrives -> IDLE, no rf write, response ignored.
REQ-041 ALU uop with rd=0 -> rf_wen_o stays 0; with PIPE_WBU_COMMIT_TRACE_EN, commit_valid_o = 1.
